// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus master: funct3 codes, FSM states, request legality.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD      = 3'd1;
   localparam logic [2:0] S_WR      = 3'd2;
   localparam logic [2:0] S_RMW_RD  = 3'd3;
   localparam logic [2:0] S_RMW_WR  = 3'd4;
   localparam logic [2:0] S_RESP    = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE   = S_IDLE,
      ST_RD     = S_RD,
      ST_WR     = S_WR,
      ST_RMW_RD = S_RMW_RD,
      ST_RMW_WR = S_RMW_WR,
      ST_RESP   = S_RESP
   } state_t;

   // Unsupported size code or a size that does not fit its natural alignment.
   function automatic logic req_illegal(input logic we, input logic [2:0] f3, input logic [1:0] off);
      logic bad;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = off[0];
         F3_W:    bad = (off != 2'b00);
         F3_BU:   bad = we;
         F3_HU:   bad = we | off[0];
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge into an existing word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] word,
   input  logic [1:0]      offset,
   input  logic [2:0]      funct3,
   input  logic [15:0]     sdata,
   output logic [XLEN-1:0] load_data_c,
   output logic [XLEN-1:0] store_word_c
);

   logic [4:0]      bshift;
   logic [4:0]      hshift;
   logic [XLEN-1:0] shifted;

   assign bshift  = {offset, 3'b000};
   assign hshift  = {offset[1], 4'b0000};
   assign shifted = word >> bshift;

   always_comb begin
      load_data_c = word;
      case (funct3)
         F3_B:    load_data_c = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data_c = {24'h0, shifted[7:0]};
         F3_H:    load_data_c = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_data_c = {16'h0, shifted[15:0]};
         default: load_data_c = word;
      endcase
   end

   always_comb begin
      store_word_c = word;
      case (funct3)
         F3_B: store_word_c = (word & ~(32'h0000_00FF << bshift)) | (XLEN'(sdata[7:0]) << bshift);
         F3_H: store_word_c = (word & ~(32'h0000_FFFF << hshift)) | (XLEN'(sdata) << hshift);
         default: store_word_c = word;
      endcase
   end

endmodule

// File: rtl/lsu_bus_master.sv
// Turns byte/half/word load-store requests into word-aligned memory transactions,
// using read-modify-write for sub-word stores.
module lsu_bus_master
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  mem_rd_en_o,
   output logic                  mem_wr_en_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic                  mem_ack_i
);

   state_t          state;
   logic [1:0]      off_q;
   logic [2:0]      f3_q;
   logic [15:0]     wdata_q;
   logic [XLEN-1:0] load_data_c;
   logic [XLEN-1:0] store_word_c;

   lsu_align u_align (
      .word         (mem_data_i),
      .offset       (off_q),
      .funct3       (f3_q),
      .sdata        (wdata_q),
      .load_data_c  (load_data_c),
      .store_word_c (store_word_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         req_ready_o  <= 1'b1;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
         mem_rd_en_o  <= 1'b0;
         mem_wr_en_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         off_q        <= '0;
         f3_q         <= '0;
         wdata_q      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i && req_ready_o) begin
                  req_ready_o <= 1'b0;
                  off_q       <= req_addr_i[1:0];
                  f3_q        <= req_funct3_i;
                  wdata_q     <= req_wdata_i[15:0];
                  if (req_illegal(req_we_i, req_funct3_i, req_addr_i[1:0])) begin
                     state        <= ST_RESP;
                     resp_valid_o <= 1'b1;
                     resp_err_o   <= 1'b1;
                     resp_rdata_o <= '0;
                  end else begin
                     mem_addr_o <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                     if (!req_we_i) begin
                        state       <= ST_RD;
                        mem_rd_en_o <= 1'b1;
                     end else if (req_funct3_i == F3_W) begin
                        state       <= ST_WR;
                        mem_wr_en_o <= 1'b1;
                        mem_data_o  <= req_wdata_i;
                     end else begin
                        state       <= ST_RMW_RD;
                        mem_rd_en_o <= 1'b1;
                     end
                  end
               end
            end
            ST_RD: begin
               if (mem_ack_i) begin
                  state        <= ST_RESP;
                  mem_rd_en_o  <= 1'b0;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b0;
                  resp_rdata_o <= load_data_c;
               end
            end
            ST_RMW_RD: begin
               if (mem_ack_i) begin
                  state       <= ST_RMW_WR;
                  mem_rd_en_o <= 1'b0;
                  mem_wr_en_o <= 1'b1;
                  mem_data_o  <= store_word_c;
               end
            end
            ST_WR, ST_RMW_WR: begin
               if (mem_ack_i) begin
                  state        <= ST_RESP;
                  mem_wr_en_o  <= 1'b0;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= 1'b0;
                  resp_rdata_o <= '0;
               end
            end
            ST_RESP: begin
               state        <= ST_IDLE;
               req_ready_o  <= 1'b1;
               resp_valid_o <= 1'b0;
               resp_err_o   <= 1'b0;
               resp_rdata_o <= '0;
            end
            default: begin
               state       <= ST_IDLE;
               req_ready_o <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_bus_master.sv
// Self-checking bench for lsu_bus_master with a word memory model and response scoreboard.
module tb_lsu_bus_master;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i, req_ready_o, req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i, req_wdata_i;
   logic        resp_valid_o, resp_err_o;
   logic [31:0] resp_rdata_o;
   logic        mem_rd_en_o, mem_wr_en_o, mem_ack_i;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        ack;

   logic [31:0] mem [0:1023];

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   lsu_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_funct3_i(req_funct3_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
      .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   // Responder: combinational read data, write commits on the acked edge.
   assign mem_ack_i  = ack;
   assign mem_data_i = mem_rd_en_o ? mem[mem_addr_o[11:2]] : 32'h0;
   always @(posedge clk) if (mem_wr_en_o && mem_ack_i) mem[mem_addr_o[11:2]] <= mem_data_o;

   // Scoreboard: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst === 1'b0 && resp_valid_o === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_resp rdata=%h err=%b with nothing expected", resp_rdata_o, resp_err_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (resp_rdata_o !== e.rdata || resp_err_o !== e.err) begin
               failures++;
               $display("FAIL sb_resp got rdata=%h err=%b expected rdata=%h err=%b",
                        resp_rdata_o, resp_err_o, e.rdata, e.err);
            end
         end
      end
      if (mem_rd_en_o === 1'b1 && mem_wr_en_o === 1'b1) begin
         failures++;
         $display("FAIL rd_wr_overlap rd=1 wr=1 expected at most one");
      end
   end

   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                       input logic push);
      for (int i = 0; i < 20 && !req_ready_o; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         failures++;
         $display("FAIL ready_timeout ready=%b expected 1", req_ready_o);
      end
      req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3; req_addr_i = addr; req_wdata_i = wdata;
      if (push) sb.push_back('{rdata: erd, err: eerr});
      @(posedge clk); #1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000; req_addr_i = 32'h0; req_wdata_i = 32'h0;
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (resp_valid_o === 1'b1) begin
            lat = c;
            break;
         end
      end
      if (lat == 0) begin
         failures++;
         $display("FAIL resp_timeout no resp_valid within 40 cycles");
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; ack = 1'b1;
      req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = 3'b000; req_addr_i = 32'h0; req_wdata_i = 32'h0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
      checks++;
      if ({resp_valid_o, resp_err_o, mem_rd_en_o, mem_wr_en_o} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_strobes got=%b exp=0000", {resp_valid_o, resp_err_o, mem_rd_en_o, mem_wr_en_o});
      end
      checks++;
      if (mem_addr_o !== 32'h0 || mem_data_o !== 32'h0 || resp_rdata_o !== 32'h0) begin
         failures++;
         $display("FAIL reset_data addr=%h data=%h rdata=%h exp all 0", mem_addr_o, mem_data_o, resp_rdata_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_loads();
      int lat;
      logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
      logic [31:0] ads [5] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100};
      logic [31:0] exs [5] = '{32'hFFFF_FFAA, 32'h0000_0088, 32'hFFFF_8899, 32'h0000_AABB, 32'h8899_AABB};
      mem[32'h100 >> 2] = 32'h8899_AABB;
      ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(1'b0, f3s[i], ads[i], 32'h0, exs[i], 1'b0, 1'b1);
         wait_resp(lat);
         checks++;
         if (lat != 2) begin failures++; $display("FAIL load_latency[%0d] got=%0d exp=2", i, lat); end
      end
   endtask

   task automatic test_rmw();
      int lat;
      send(1'b1, F3_H, 32'h102, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (mem_rd_en_o !== 1'b1 || mem_wr_en_o !== 1'b0 || mem_addr_o !== 32'h100) begin
         failures++;
         $display("FAIL rmw_read rd=%b wr=%b addr=%h exp rd=1 wr=0 addr=00000100", mem_rd_en_o, mem_wr_en_o, mem_addr_o);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_wr_en_o !== 1'b1 || mem_rd_en_o !== 1'b0 || mem_data_o !== 32'h1234_AABB) begin
         failures++;
         $display("FAIL rmw_write wr=%b rd=%b data=%h exp wr=1 rd=0 data=1234aabb", mem_wr_en_o, mem_rd_en_o, mem_data_o);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL rmw_resp_cycle3 got=%b exp=1", resp_valid_o); end
      @(posedge clk); #1;
      send(1'b0, F3_W, 32'h100, 32'h0, 32'h1234_AABB, 1'b0, 1'b1);
      wait_resp(lat);
      checks++;
      if (lat != 2) begin failures++; $display("FAIL rmw_readback_latency got=%0d exp=2", lat); end
   endtask

   task automatic test_errors();
      logic        wes [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [2:0]  f3s [4] = '{F3_W, F3_H, F3_BU, 3'b011};
      logic [31:0] ads [4] = '{32'h102, 32'h101, 32'h100, 32'h100};
      for (int i = 0; i < 4; i++) begin
         send(wes[i], f3s[i], ads[i], 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1);
         for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            checks++;
            if (mem_rd_en_o !== 1'b0 || mem_wr_en_o !== 1'b0) begin
               failures++;
               $display("FAIL err_mem_access[%0d] cyc=%0d rd=%b wr=%b exp 0 0", i, c, mem_rd_en_o, mem_wr_en_o);
            end
            if (c == 1) begin
               checks++;
               if (resp_valid_o !== 1'b1) begin failures++; $display("FAIL err_resp_cycle1[%0d] got=%b exp=1", i, resp_valid_o); end
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_wait_states();
      int lat;
      ack = 1'b0;
      send(1'b1, F3_W, 32'h200, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (mem_wr_en_o !== 1'b1 || mem_addr_o !== 32'h200 || mem_data_o !== 32'hCAFE_F00D || resp_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_hold cyc=%0d wr=%b addr=%h data=%h rv=%b exp 1/00000200/cafef00d/0",
                     c, mem_wr_en_o, mem_addr_o, mem_data_o, resp_valid_o);
         end
         @(posedge clk); #1;
      end
      ack = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_wr_en_o !== 1'b1) begin failures++; $display("FAIL wait_fourth_cycle wr=%b exp=1", mem_wr_en_o); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (resp_valid_o !== 1'b1 || mem_wr_en_o !== 1'b0) begin
         failures++;
         $display("FAIL wait_resp_after_ack rv=%b wr=%b exp rv=1 wr=0", resp_valid_o, mem_wr_en_o);
      end
      @(posedge clk); #1;
      send(1'b0, F3_W, 32'h200, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
      wait_resp(lat);
   endtask

   task automatic test_reset_mid();
      mem[32'h300 >> 2] = 32'h1122_3344;
      send(1'b1, F3_B, 32'h301, 32'h0000_00A5, 32'h0, 1'b0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (mem_wr_en_o !== 1'b1) begin failures++; $display("FAIL midrst_in_rmw_wr wr=%b exp=1", mem_wr_en_o); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({resp_valid_o, mem_rd_en_o, mem_wr_en_o, resp_err_o} !== 4'b0000 || req_ready_o !== 1'b1 ||
          mem_addr_o !== 32'h0 || mem_data_o !== 32'h0 || resp_rdata_o !== 32'h0) begin
         failures++;
         $display("FAIL midrst_outputs rv=%b rd=%b wr=%b err=%b rdy=%b addr=%h data=%h exp idle reset values",
                  resp_valid_o, mem_rd_en_o, mem_wr_en_o, resp_err_o, req_ready_o, mem_addr_o, mem_data_o);
      end
      checks++;
      if (mem[32'h300 >> 2] !== 32'h1122_A544) begin
         failures++;
         $display("FAIL midrst_commit word=%h exp=1122a544", mem[32'h300 >> 2]);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_no_resp cyc=%0d rv=%b exp=0", c, resp_valid_o); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      test_reset();
      test_loads();
      test_rmw();
      test_errors();
      test_wait_states();
      test_reset_mid();
      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin failures++; $display("FAIL sb_drain pending=%0d exp=0", sb.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
